// File: rtl/mult.sv
// Three-stage pipelined unsigned multiplier: operand register, nibble partial-product
// reduction into two partial sums, final add. A valid flag travels alongside the data.
module mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid
);

    localparam int unsigned NumNib = WIDTH / 4;
    localparam int unsigned PpW    = WIDTH + 4;
    localparam int unsigned ProdW  = 2 * WIDTH;

    // Stage 1: registered operands
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             v1_q, v1_d;

    // Stage 2: two partial sums
    logic [ProdW-1:0] sum_even_q, sum_even_d;
    logic [ProdW-1:0] sum_odd_q, sum_odd_d;
    logic             v2_q, v2_d;

    // Stage 3: final product
    logic [ProdW-1:0] prod_q, prod_d;
    logic             v3_q, v3_d;

    logic [PpW-1:0]   pp [NumNib];

    // Each nibble of A times the full B fits in WIDTH+4 bits.
    for (genvar g = 0; g < NumNib; g++) begin : g_pp
        assign pp[g] = PpW'(a_q[4*g +: 4]) * PpW'(b_q);
    end

    always_comb begin
        a_d  = multiplier;
        b_d  = multiplicand;
        v1_d = in_valid;
    end

    // Even nibbles accumulate into one sum, odd nibbles into the other; neither can
    // exceed the full product, so ProdW bits suffice for both.
    always_comb begin
        sum_even_d = '0;
        sum_odd_d  = '0;
        for (int unsigned i = 0; i < NumNib; i++) begin
            if ((i % 2) == 0) begin
                sum_even_d = sum_even_d + (ProdW'(pp[i]) << (4 * i));
            end else begin
                sum_odd_d = sum_odd_d + (ProdW'(pp[i]) << (4 * i));
            end
        end
        v2_d = v1_q;
    end

    always_comb begin
        prod_d = sum_even_q + sum_odd_q;
        v3_d   = v2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            v1_q       <= 1'b0;
            sum_even_q <= '0;
            sum_odd_q  <= '0;
            v2_q       <= 1'b0;
            prod_q     <= '0;
            v3_q       <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            v1_q       <= v1_d;
            sum_even_q <= sum_even_d;
            sum_odd_q  <= sum_odd_d;
            v2_q       <= v2_d;
            prod_q     <= prod_d;
            v3_q       <= v3_d;
        end
    end

    assign product   = prod_q;
    assign out_valid = v3_q;

endmodule

// File: tb/tb_mult.sv
// Directed and randomised checks of the 3-cycle pipelined multiplier against
// hand-computed products and a behavioural reference.
module tb_mult;

    localparam int unsigned W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [W-1:0]   multiplier;
    logic [W-1:0]   multiplicand;
    logic [2*W-1:0] product;
    logic           out_valid;

    int checks   = 0;
    int failures = 0;

    mult #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .product      (product),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid     = v;
        multiplier   = a;
        multiplicand = b;
    endtask

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Directed table: valid, A, B, hand-computed product
    localparam int N = 11;
    logic           tv [N] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    logic [W-1:0]   ta [N] = '{5, 8, 7, 5, 0, 1, 65535, 32768, 3, 9, 6};
    logic [W-1:0]   tb [N] = '{8, 8, 8, 2, 65535, 65535, 65535, 2, 4, 9, 7};
    logic [2*W-1:0] te [N] = '{40, 64, 56, 10, 0, 65535, 32'd4294836225, 65536, 12, 81, 42};

    localparam int R = 10000;
    logic           rv [R];
    logic [2*W-1:0] re [R];

    initial begin
        // Reset with live-looking inputs.
        rst = 1'b1;
        drive(1'b1, W'($urandom), W'($urandom));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_product", product, '0);
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            drive(1'b1, W'($urandom), W'($urandom));
        end
        rst = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("post_rst_product", product, '0);

        // Directed vectors, boundaries and a bubble; result of step i appears after step i+2.
        for (int i = 0; i < N + 2; i++) begin
            if (i < N) drive(tv[i], ta[i], tb[i]);
            else drive(1'b0, '0, '0);
            tick();
            if (i < 2) begin
                chk("fill_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                chk($sformatf("dir_valid[%0d]", i - 2), {31'b0, out_valid}, {31'b0, tv[i-2]});
                if (tv[i-2]) chk($sformatf("dir_product[%0d]", i - 2), product, te[i-2]);
            end
        end

        // Reset while two pairs are in flight.
        drive(1'b1, 16'd100, 16'd200);
        tick();
        drive(1'b1, 16'd300, 16'd400);
        tick();
        rst = 1'b1;
        drive(1'b0, '0, '0);
        tick();
        chk("midrst_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_product", product, '0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_drain_valid", {31'b0, out_valid}, 32'd0);
            chk("midrst_drain_product", product, '0);
        end

        // Random regression against a behavioural product.
        for (int i = 0; i < R + 2; i++) begin
            if (i < R) begin
                logic [W-1:0] a, b;
                a = W'($urandom);
                b = W'($urandom);
                if (i % 7 == 0) a = 16'hFFFF;
                rv[i] = 1'($urandom);
                re[i] = {16'b0, a} * {16'b0, b};
                drive(rv[i], a, b);
            end else begin
                drive(1'b0, '0, '0);
            end
            tick();
            if (i >= 2) begin
                chk("rand_valid", {31'b0, out_valid}, {31'b0, rv[i-2]});
                if (rv[i-2]) chk("rand_product", product, re[i-2]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult.md
Name: mult

Overview:
- Pipelined unsigned integer multiplier: multiplier × multiplicand → full-width product.
- Used as a shared arithmetic datapath block in the team's designs.
- Accepts a new operand pair every clock cycle.
- Returns each product after a fixed 3-cycle latency, with a valid flag travelling alongside the data.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits. Must be a multiple of 4, minimum 4.

Ports:
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair on multiplier/multiplicand is valid this cycle
- multiplier  input  WIDTH  unsigned operand A
- multiplicand  input  WIDTH  unsigned operand B
- product  output  2*WIDTH  unsigned A*B, registered
- out_valid  output  1  product holds a valid result this cycle

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All flops update only on the rising edge of clk.
- Reset:
  - While rst=1 at a rising edge, all pipeline registers clear to 0.
  - After that edge, product=0 and out_valid=0.
  - Reset applied mid-operation discards every in-flight operand pair; no stale result ever appears after reset deasserts.
- Arithmetic:
  - Both operands unsigned.
  - product = multiplier*multiplicand, exact, full 2*WIDTH bits; no truncation or overflow possible.
  - Maximum case: (2^WIDTH-1)^2.
- Pipeline, latency 3, throughput 1 per cycle:
  - Stage 1 (edge N): register multiplier, multiplicand and in_valid.
  - Stage 2 (edge N+1):
    - Split the registered multiplier into WIDTH/4 nibbles.
    - Form each nibble × multiplicand partial product (WIDTH+4 bits).
    - Shift each by 4*i and add them pairwise into two partial sums.
    - Register the two partial sums plus valid.
  - Stage 3 (edge N+2): add the two partial sums, register into product, and register valid into out_valid.
  - Net effect: inputs sampled at edge N appear on product/out_valid after edge N+2, i.e. the third rising edge counting edge N as the first.
- Valid handling:
  - in_valid=0 inserts a bubble; that slot's out_valid is 0.
  - product is not required to hold its old value during a bubble. Data registers advance every cycle regardless of valid (no clock enable).
  - Verification checks product only when out_valid=1.
- No back-pressure, no stall input; the pipeline always advances.
- Consecutive identical operand pairs produce identical results on consecutive cycles.
- No combinational path from any input to any output.

Test Plan:
- Reset then hold: assert rst 2 cycles with in_valid=1 and random operands -> product=0, out_valid=0 throughout and for 3 cycles after release until the first post-reset valid pair emerges.
- Directed sequence on consecutive cycles, in_valid=1: (5,8),(8,8),(7,8),(5,2) -> products 40, 64, 56, 10 on consecutive cycles, each 3 cycles after its input, each with out_valid=1.
- Boundaries:
  - (0,65535) -> 0
  - (1,65535) -> 65535
  - (65535,65535) -> 4294836225
  - (32768,2) -> 65536
- Bubbles: pattern in_valid=1,0,1 with (3,4),(9,9),(6,7) -> out_valid=1,0,1; products 12 and 42 on the valid slots.
- Reset mid-pipeline: issue (100,200) and (300,400) on consecutive cycles, assert rst on the following cycle -> neither 20000 nor 120000 ever appears with out_valid=1.
- Random regression: 10k random pairs with random in_valid -> every valid product equals a reference model result delayed by 3 cycles.
